filter_ctrl: RTL and testbench

Control stage for the averaging noise filter's 8-entry circular sample buffer.
- Tracks occupancy and generates the read/write addresses and full/empty flags that drive the filter datapath.
- The datapath writes when (write & ~full) | (read & write); this block advances its pointers under the same rule, so address and storage never diverge.
- Also flags when the window is primed, i.e. holds DEPTH valid samples and the averaging output is meaningful.

---
 rtl/filter_ctrl.sv | 127 ++++++++++++
 tb/tb_filter_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/filter_ctrl.sv
// Read/write pointer, occupancy and window-primed control for the filter's circular sample buffer.
// Optional rejected-write counter (drop_cnt) is enabled by defining FILTER_CTRL_DROP_CNT_EN.
module filter_ctrl #(
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read,
    input  logic                  write,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
`ifdef FILTER_CTRL_DROP_CNT_EN
    output logic [7:0]            drop_cnt,
`endif
    output logic                  primed
);

    localparam logic [1:0] StEmpty   = 2'd0;
    localparam logic [1:0] StPartial = 2'd1;
    localparam logic [1:0] StFull    = 2'd2;

    localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ZeroCnt  = '0;

    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [1:0]            state_q, state_d;
    logic                  primed_q, primed_d;
    logic                  wr_acc, rd_acc;

    // Write accept matches the datapath's write enable so storage and addresses stay aligned.
    assign wr_acc = write & ((state_q != StFull) | read);
    assign rd_acc = read & (state_q != StEmpty);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: begin
                if (wr_acc) begin
                    state_d = (count_d == DepthCnt) ? StFull : StPartial;
                end
            end
            StPartial: begin
                if (count_d == DepthCnt) begin
                    state_d = StFull;
                end else if (count_d == ZeroCnt) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (rd_acc && !wr_acc) begin
                    state_d = StPartial;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Sticky: once the window has held DEPTH samples, only reset clears it.
    assign primed_d = primed_q | (count_d == DepthCnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StEmpty;
            primed_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            primed_q <= primed_d;
        end
    end

    assign read_addr  = rd_ptr_q;
    assign write_addr = wr_ptr_q;
    assign count      = count_q;
    assign full       = (state_q == StFull);
    assign empty      = (state_q == StEmpty);
    assign primed     = primed_q;

`ifdef FILTER_CTRL_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (write && full && !read && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_filter_ctrl.sv
// Self-checking bench for filter_ctrl: directed vector table, reset corner case and a
// randomized run against an occupancy model built from accepted push/pop totals.
module tb_filter_ctrl;

    logic       clk;
    logic       reset_n;
    logic       read;
    logic       write;
    logic [2:0] read_addr;
    logic [2:0] write_addr;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       primed;
`ifdef FILTER_CTRL_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_chk;
    int n_err;

    filter_ctrl #(.ADDR_WIDTH(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .read       (read),
        .write      (write),
        .read_addr  (read_addr),
        .write_addr (write_addr),
        .full       (full),
        .empty      (empty),
        .count      (count),
`ifdef FILTER_CTRL_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .primed     (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rd;
        logic wr;
        int   cnt;
        int   wa;
        int   ra;
        logic f;
        logic e;
        logic p;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rd, logic wr, int cnt, int wa, int ra,
                                logic f, logic e, logic p);
        vec_t v;
        v.rd = rd; v.wr = wr; v.cnt = cnt; v.wa = wa; v.ra = ra;
        v.f = f; v.e = e; v.p = p;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input int wa, input int ra,
                           input int f, input int e, input int p);
        chk({tag, ".count"}, int'(count), cnt);
        chk({tag, ".write_addr"}, int'(write_addr), wa);
        chk({tag, ".read_addr"}, int'(read_addr), ra);
        chk({tag, ".full"}, int'(full), f);
        chk({tag, ".empty"}, int'(empty), e);
        chk({tag, ".primed"}, int'(primed), p);
    endtask

    // Inputs change on the falling edge; outputs sampled 1ns after the rising edge.
    task automatic step(input logic r, input logic w);
        @(negedge clk);
        read  = r;
        write = w;
        @(posedge clk);
        #1;
    endtask

    // Reference model: totals of accepted pushes/pops; occupancy is their difference.
    int m_wr, m_rd, m_drop;
    bit m_primed;

    task automatic model_step(input logic r, input logic w);
        int  occ;
        bit  wa_ok, ra_ok;
        occ   = m_wr - m_rd;
        wa_ok = w && (occ < 8 || r);
        ra_ok = r && (occ > 0);
        if (w && occ == 8 && !r && m_drop < 255) m_drop++;
        if (wa_ok) m_wr++;
        if (ra_ok) m_rd++;
        if (m_wr - m_rd == 8) m_primed = 1'b1;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        read    = 1'b0;
        write   = 1'b0;
        reset_n = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 1, 0);
`ifdef FILTER_CTRL_DROP_CNT_EN
        chk("reset.drop_cnt", int'(drop_cnt), 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table
        add(1, 1, 1, 1, 0, 0, 0, 0);          // read&write while empty: write only
        add(1, 0, 0, 1, 1, 0, 1, 0);          // drain back to empty, primed still 0
        add(1, 0, 0, 1, 1, 0, 1, 0);          // read while empty ignored
        add(0, 0, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++)
            add(0, 1, i + 1, (2 + i) % 8, 1, i == 7, 0, i == 7);
        for (int i = 0; i < 3; i++)
            add(0, 1, 8, 1, 1, 1, 0, 1);      // rejected writes while full
        for (int i = 0; i < 10; i++)
            add(1, 1, 8, (2 + i) % 8, (2 + i) % 8, 1, 0, 1);
        add(1, 0, 7, 3, 4, 0, 0, 1);
        for (int i = 0; i < 7; i++)
            add(1, 0, 6 - i, 3, (5 + i) % 8, 0, i == 6, 1);

        foreach (vecs[k]) begin
            step(vecs[k].rd, vecs[k].wr);
            chk_all($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].wa, vecs[k].ra,
                    vecs[k].f, vecs[k].e, vecs[k].p);
        end
`ifdef FILTER_CTRL_DROP_CNT_EN
        chk("table.drop_cnt", int'(drop_cnt), 3);
`endif

        // Randomized run continuing from the table's end state
        m_wr = 3; m_rd = 3; m_drop = 3; m_primed = 1'b1;
        for (int i = 0; i < 600; i++) begin
            int   bias;
            logic r, w;
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            w = ($urandom_range(0, 99) < bias);
            r = ($urandom_range(0, 99) < 100 - bias);
            step(r, w);
            model_step(r, w);
            chk_all($sformatf("rnd%0d", i), m_wr - m_rd, m_wr % 8, m_rd % 8,
                    int'(m_wr - m_rd == 8), int'(m_wr == m_rd), int'(m_primed));
`ifdef FILTER_CTRL_DROP_CNT_EN
            chk($sformatf("rnd%0d.drop_cnt", i), int'(drop_cnt), m_drop);
`endif
        end

        // Asynchronous reset between edges after 5 writes
        step(0, 0);
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        step(0, 0);
        for (int i = 0; i < 5; i++) step(0, 1);
        chk("pre_rst.count", int'(count), 5);
        @(negedge clk);
        write = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 1, 0);
`ifdef FILTER_CTRL_DROP_CNT_EN
        chk("async_rst.drop_cnt", int'(drop_cnt), 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 1);
        chk_all("post_rst", 1, 1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
